sync_pattern_tx: RTL and testbench

Serial frame transmitter that emits a fixed sync marker (default 1011) followed by a parallel data word, MSB first, on a single-bit line. It is the sending end of the team's serial sync-marker link. Upstream logic hands it words over a valid/ready handshake, and receive-side sequence detectors lock onto the marker. The line idles at 0, and every frame ends with a programmable all-zero gap.

---
 rtl/sync_link_pkg.sv | 21 ++
 rtl/bit_tick_gen.sv | 32 +++
 rtl/sync_pattern_tx.sv | 127 ++++++++++++
 tb/tb_sync_pattern_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sync_link_pkg.sv
// Shared definitions for the serial sync-marker link.
// Holds the transmitter state encoding, the default marker constants that
// both the transmitter and the receive-side detectors use, and a small
// integer max helper for parameter arithmetic.
package sync_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int         SYNC_W_DEFAULT       = 4;
    localparam logic [3:0] SYNC_PATTERN_DEFAULT = 4'b1011;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer for the serial transmitter.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   clear  - restart the bit period (asserted on word accept)
//   tick   - high on the last clk cycle of each bit period
// With CLKS_PER_BIT=1 the counter never leaves 0, so tick is constantly 1.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/sync_pattern_tx.sv
// Serial frame transmitter: sync marker, then payload MSB first, then an
// all-zero gap. Line idles at 0.
// Ports:
//   clk, reset  - clock (rising edge), asynchronous active-high reset
//   in_valid    - upstream word available
//   in_data     - payload word
//   in_ready    - high only in IDLE (combinational from state)
//   tx_bit      - serial line, registered
//   tx_active   - high while marker or payload bits are on the line
//   frame_done  - one-cycle pulse during the final cycle of the frame
module sync_pattern_tx
    import sync_link_pkg::*;
#(
    parameter int                SYNC_W       = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int                DATA_W       = 8,
    parameter int                CLKS_PER_BIT = 1,
    parameter int                GAP_BITS     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int BW       = $clog2(imax(imax(SYNC_W, DATA_W), imax(GAP_BITS, 1)) + 1);
    localparam int F        = (SYNC_W + DATA_W + GAP_BITS) * CLKS_PER_BIT;
    localparam int FW       = $clog2(F + 1);
    localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    tx_state_t         state, state_n;
    logic [SYNC_W-1:0] sync_sr;
    logic [DATA_W-1:0] data_sr;
    logic [BW-1:0]     bit_cnt;
    logic [FW-1:0]     fcyc;    // cycle number within the current frame, 1..F
    logic              tick;
    logic              accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid;

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = SYNC;
            SYNC: if (tick && bit_cnt == BW'(SYNC_W - 1)) state_n = DATA;
            DATA: if (tick && bit_cnt == BW'(DATA_W - 1))
                      state_n = (GAP_BITS > 0) ? GAP : IDLE;
            GAP:  if (tick && bit_cnt == BW'(GAP_LAST)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The line registers are loaded with the value of the bit that starts
    // at this edge, so the first marker bit appears right after accept.
    // frame_done is set one edge early from the frame cycle count so that it
    // is high during the final cycle rather than after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_sr    <= '0;
            data_sr    <= '0;
            bit_cnt    <= '0;
            fcyc       <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                sync_sr   <= SYNC_PATTERN << 1;
                data_sr   <= in_data;
                bit_cnt   <= '0;
                fcyc      <= FW'(1);
                tx_bit    <= SYNC_PATTERN[SYNC_W-1];
                tx_active <= 1'b1;
            end else if (state != IDLE) begin
                fcyc       <= fcyc + FW'(1);
                frame_done <= (fcyc == FW'(F - 1));
                if (tick) begin
                    bit_cnt <= (state_n != state) ? '0 : bit_cnt + BW'(1);
                    case (state)
                        SYNC: begin
                            if (state_n == DATA) begin
                                tx_bit  <= data_sr[DATA_W-1];
                                data_sr <= data_sr << 1;
                            end else begin
                                tx_bit  <= sync_sr[SYNC_W-1];
                                sync_sr <= sync_sr << 1;
                            end
                        end
                        DATA: begin
                            if (state_n == DATA) begin
                                tx_bit  <= data_sr[DATA_W-1];
                                data_sr <= data_sr << 1;
                            end else begin
                                tx_bit    <= 1'b0;
                                tx_active <= 1'b0;
                            end
                        end
                        default: tx_bit <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_pattern_tx.sv
module tb_sync_pattern_tx;

    typedef struct {
        logic [7:0]  data;
        logic [13:0] stream;   // expected tx_bit for cycles 1..14, MSB first
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, tx_bit, tx_active, frame_done;
    logic       in_valid3 = 1'b0;
    logic [7:0] in_data3 = '0;
    logic       in_ready3, tx_bit3, tx_active3, frame_done3;

    int total = 0;
    int bad = 0;
    logic [3:0] expq[$];
    bit drv_done = 1'b0;
    vec_t tbl[6];

    always #5 clk = ~clk;

    sync_pattern_tx dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_bit(tx_bit), .tx_active(tx_active),
        .frame_done(frame_done)
    );

    sync_pattern_tx #(.CLKS_PER_BIT(3), .GAP_BITS(0)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .tx_bit(tx_bit3), .tx_active(tx_active3),
        .frame_done(frame_done3)
    );

    // Returns {tx_bit, tx_active, frame_done, in_ready} for frame cycle c
    // (c=0 is the handshake cycle; c>F is idle).
    function automatic logic [3:0] model(input logic [7:0] d, input int c,
                                         input int cpb, input int gap);
        logic [3:0] p;
        int f, b;
        logic bt;
        p = 4'b1011;
        f = (12 + gap) * cpb;
        if (c == 0 || c > f) return 4'b0001;
        b = (c - 1) / cpb;
        if (b < 4)       bt = p[3-b];
        else if (b < 12) bt = d[11-b];
        else             bt = 1'b0;
        return {bt, (b < 12), (c == f), 1'b0};
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (tx_bit,tx_active,frame_done,in_ready)", name, got, exp);
        end
    endtask

    // Drive one default-parameter frame from table entry idx and queue the
    // expected line state for cycles 0..14. Returns in cycle 14.
    task automatic send(input int idx, input bit hold, input int pulse);
        logic [3:0] m;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = tbl[idx].data;
        expq.push_back(4'b0001);
        for (int c = 1; c <= 14; c++) begin
            m = model(tbl[idx].data, c, 1, 2);
            expq.push_back({tbl[idx].stream[14-c], m[2:0]});
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == pulse) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end else if (!hold) begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            expq.push_back(4'b0001);
        end
    endtask

    initial begin
        logic [3:0] m;
        tbl[0] = '{8'hA5, 14'b10111010010100};
        tbl[1] = '{8'hFF, 14'b10111111111100};
        tbl[2] = '{8'h00, 14'b10110000000000};
        tbl[3] = '{8'h81, 14'b10111000000100};
        tbl[4] = '{8'hC3, 14'b10111100001100};
        tbl[5] = '{8'h0B, 14'b10110000101100};

        // reset state
        #3;
        check("reset_state", {tx_bit, tx_active, frame_done, in_ready}, 4'b0001);
        check("reset_state3", {tx_bit3, tx_active3, frame_done3, in_ready3}, 4'b0001);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // CLKS_PER_BIT=3, GAP_BITS=0, 8'h01: 36-cycle frame
        @(posedge clk); #1;
        in_valid3 = 1'b1;
        in_data3  = 8'h01;
        #3 check("cpb3_c0", {tx_bit3, tx_active3, frame_done3, in_ready3}, 4'b0001);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            #3 check($sformatf("cpb3_c%0d", c),
                     {tx_bit3, tx_active3, frame_done3, in_ready3}, model(8'h01, c, 3, 0));
            @(posedge clk); #1;
        end

        // reset mid-frame, asynchronous
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        m = model(8'hA5, 7, 1, 2);
        check("midframe_pre_reset", {tx_bit, tx_active, frame_done, in_ready}, m);
        #2 reset = 1'b1;
        #1 check("async_reset", {tx_bit, tx_active, frame_done, in_ready}, 4'b0001);
        repeat (2) @(negedge clk);
        check("reset_hold", {tx_bit, tx_active, frame_done, in_ready}, 4'b0001);
        reset = 1'b0;
        @(negedge clk);
        check("after_release", {tx_bit, tx_active, frame_done, in_ready}, 4'b0001);

        fork
            begin
                send(4, 1'b0, 0);          // clean C3 frame after reset
                idle(3);
                send(0, 1'b0, 0);          // A5 single frame
                idle(2);
                send(1, 1'b1, 0);          // FF then 00 back to back
                send(2, 1'b1, 0);
                @(posedge clk); #1;
                in_valid = 1'b0;
                expq.push_back(4'b0001);
                idle(2);
                send(3, 1'b0, 5);          // 81 with 3C pulsed while busy
                idle(18);                  // no extra frame may follow
                send(5, 1'b0, 0);          // 0B: marker pattern inside payload
                idle(2);
                drv_done = 1'b1;
            end
            begin
                logic [3:0] e;
                int guard;
                guard = 0;
                while (!(drv_done && expq.size() == 0) && guard < 5000) begin
                    @(negedge clk);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check($sformatf("stream_t%0t", $time),
                              {tx_bit, tx_active, frame_done, in_ready}, e);
                    end
                    guard++;
                end
                if (guard >= 5000) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_timeout pending=%0d required=0", expq.size());
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
